// File: rtl/fm_bram_arb_pkg.sv
// fm_bram_arb_pkg: shared types for the feature-map BRAM arbiter
package fm_bram_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  typedef logic req_id_t;
  localparam int STAT_W = 32;
endpackage

// File: rtl/fm_bram_rr_pick.sv
// fm_bram_rr_pick: 2-way round-robin pick with bounded burst lock
module fm_bram_rr_pick import fm_bram_arb_pkg::*; #(
  parameter int MAX_BURST = 16,
  parameter int CW = $clog2(MAX_BURST + 1)
) (
  input  logic          v0,
  input  logic          v1,
  input  arb_state_t    state,
  input  req_id_t       last_grant,
  input  logic [CW-1:0] burst_cnt,
  output req_id_t       gnt_id,
  output logic          gnt_v
);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
  req_id_t own;
  logic own_v, oth_v;
  always_comb begin
    own = state == OWN1;
    own_v = own ? v1 : v0;
    oth_v = own ? v0 : v1;
    gnt_v = v0 | v1;
    gnt_id = (state == IDLE) ? ((v0 & v1) ? ~last_grant : v1)
           : ((own_v & (~oth_v | (burst_cnt < LAST))) ? own : ~own);
  end
endmodule

// File: rtl/fm_bram_arbiter.sv
// fm_bram_arbiter: shares one single-port feature-map BRAM between two requesters.
// Define FM_BRAM_ARB_STATS_EN to add saturating grant/conflict counters.
module fm_bram_arbiter import fm_bram_arb_pkg::*; #(
  parameter int BRAM_ADDR_WIDTH = 20,
  parameter int BRAM_DATA_WIDTH = 64,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r0_valid,
  input  logic                       r1_valid,
  output logic                       r0_ready,
  output logic                       r1_ready,
  input  logic                       r0_we,
  input  logic                       r1_we,
  input  logic [BRAM_ADDR_WIDTH-1:0] r0_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0] r1_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] r0_wdata,
  input  logic [BRAM_DATA_WIDTH-1:0] r1_wdata,
  output logic                       r0_rvalid,
  output logic                       r1_rvalid,
  output logic [BRAM_DATA_WIDTH-1:0] r0_rdata,
  output logic [BRAM_DATA_WIDTH-1:0] r1_rdata,
  output logic                       bram_en,
  output logic                       bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0] bram_din,
  input  logic [BRAM_DATA_WIDTH-1:0] bram_dout
`ifdef FM_BRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]          stat_grant0,
  output logic [STAT_W-1:0]          stat_grant1,
  output logic [STAT_W-1:0]          stat_conflict
`endif
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
  arb_state_t state;
  req_id_t last_grant, gnt_id;
  logic gnt_v, acc, sel_we;
  logic [CW-1:0] burst_cnt;
  logic [BRAM_ADDR_WIDTH-1:0] addr_q, sel_addr;
  logic [BRAM_DATA_WIDTH-1:0] din_q, sel_din;
  fm_bram_rr_pick #(.MAX_BURST(MAX_BURST), .CW(CW)) u_pick (
    .v0(r0_valid), .v1(r1_valid), .state(state), .last_grant(last_grant),
    .burst_cnt(burst_cnt), .gnt_id(gnt_id), .gnt_v(gnt_v)
  );
  always_comb begin
    acc = gnt_v & ~rst;
    sel_we = gnt_id ? r1_we : r0_we;
    sel_addr = gnt_id ? r1_addr : r0_addr;
    sel_din = gnt_id ? r1_wdata : r0_wdata;
  end
  assign r0_ready = acc & ~gnt_id;
  assign r1_ready = acc & gnt_id;
  assign bram_en = acc;
  assign bram_we = acc & sel_we;
  // Address/data hold their last driven value on idle cycles to avoid toggling the BRAM pins
  assign bram_addr = acc ? sel_addr : addr_q;
  assign bram_din = acc ? sel_din : din_q;
  assign r0_rdata = bram_dout;
  assign r1_rdata = bram_dout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      burst_cnt <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
    end else begin
      r0_rvalid <= acc & ~gnt_id & ~sel_we;
      r1_rvalid <= acc & gnt_id & ~sel_we;
      if (acc) begin
        state <= gnt_id ? OWN1 : OWN0;
        last_grant <= gnt_id;
        burst_cnt <= (state != (gnt_id ? OWN1 : OWN0)) ? '0
                   : (burst_cnt == LAST) ? LAST : burst_cnt + CW'(1);
        addr_q <= sel_addr;
        din_q <= sel_din;
      end else begin
        state <= IDLE;
        burst_cnt <= '0;
      end
    end
`ifdef FM_BRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_conflict <= '0;
    end else begin
      if (r0_ready && stat_grant0 != '1) stat_grant0 <= stat_grant0 + STAT_W'(1);
      if (r1_ready && stat_grant1 != '1) stat_grant1 <= stat_grant1 + STAT_W'(1);
      if (r0_valid && r1_valid && stat_conflict != '1) stat_conflict <= stat_conflict + STAT_W'(1);
    end
`endif
endmodule

// File: doc/fm_bram_arbiter.md
Name: fm_bram_arbiter

Overview:
- Two-requester arbiter that shares one single-port feature-map BRAM (1-cycle registered read, read-first on write) between requester 0 (DDR loader/unloader) and requester 1 (compute datapath).
- Owns the BRAM en/we/addr/din pins.
- Round-robin with a bounded burst lock, so a streaming requester keeps the port for up to MAX_BURST back-to-back accesses.
- Routes read data back to the requester that issued the read.

Parameters:
- BRAM_ADDR_WIDTH, 20, address width of BRAM and both requesters
- BRAM_DATA_WIDTH, 64, data width
- MAX_BURST, 16, max consecutive grants to one requester while the other is waiting (>=1)

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- r0_valid, r1_valid  in  1  request valid, requester 0/1
- r0_ready, r1_ready  out  1  request accepted this cycle (combinational)
- r0_we, r1_we  in  1  1=write, 0=read
- r0_addr, r1_addr  in  BRAM_ADDR_WIDTH  access address
- r0_wdata, r1_wdata  in  BRAM_DATA_WIDTH  write data
- r0_rvalid, r1_rvalid  out  1  read data valid (registered)
- r0_rdata, r1_rdata  out  BRAM_DATA_WIDTH  read data, qualified by rN_rvalid
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  BRAM_ADDR_WIDTH  BRAM address
- bram_din  out  BRAM_DATA_WIDTH  BRAM write data
- bram_dout  in  BRAM_DATA_WIDTH  BRAM registered read data

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=1 (so requester 0 wins first), burst_cnt=0, r0_rvalid=r1_rvalid=0. Combinational outputs are 0 while rst=1: ready, bram_en, bram_we.
- Handshake: a transfer occurs in a cycle where rN_valid && rN_ready. At most one ready is high per cycle.
- The requester must hold valid/we/addr/wdata stable until accepted.
- BRAM drive, in the accept cycle: bram_en=1; bram_we=granted we; bram_addr/bram_din from the granted requester.
- With no accept: bram_en=0, and addr/din hold the last driven value.
- Read latency: a read accepted in cycle T gives rN_rvalid=1 in T+1 for exactly 1 cycle, with rN_rdata=bram_dout.
  - rdata outputs are bram_dout passed through to both requesters; only rvalid is steered.
  - An accepted write produces no rvalid.
- Full throughput: one access per cycle, with no bubbles on requester switch.
- FSM states: IDLE, OWN0, OWN1.
  - IDLE: if exactly one valid, grant it. If both valid, grant the requester != last_grant.
  - OWNn, same requester still valid and (other idle or burst_cnt < MAX_BURST-1): grant n again, burst_cnt++.
  - OWNn, other valid and burst_cnt == MAX_BURST-1: grant the other, move to OWNm, burst_cnt=0.
  - OWNn, owner drops valid: if the other is valid, grant it the same cycle (OWNm, burst_cnt=0); otherwise go to IDLE.
- Arbitration decisions use the current cycle's valids and registered state only; there is no combinational path from ready back to valid.
- burst_cnt saturates at MAX_BURST-1 while the other requester is idle; it never wraps.
- MAX_BURST=1 gives strict alternation whenever both requesters are valid.
- last_grant updates on every accept.
- Simultaneous read (T) and a new request (T+1): legal. The T+1 access does not disturb the T+1 rvalid/rdata.
- rst asserted mid-burst: any pending rvalid is dropped (cleared asynchronously). No BRAM access is issued during reset.

Optional Feature:
- Macro FM_BRAM_ARB_STATS_EN.
- Defined: adds outputs stat_grant0, stat_grant1 (32-bit, count accepts per requester) and stat_conflict (32-bit, counts cycles with both valid and one not granted).
  - All counters are cleared by rst and saturate at 2^32-1.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fm_bram_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t
  - typedef logic req_id_t
  - localparam STAT_W = 32
- One sub-module, fm_bram_rr_pick: combinational 2-way pick from valids, state, last_grant and burst_cnt; outputs grant id and grant-valid.
- The top level holds the registers, BRAM muxing and rvalid steering.

Test Plan:
- Reset with both valid → first accept at the cycle after rst deasserts goes to r0. Reads addr 0x00005 → r0_rvalid=1 the next cycle with the previously written data 0xDEAD_BEEF_0000_0005.
- r1 alone issues 4 reads, addr 0..3 → r1_ready=1 for 4 consecutive cycles. r1_rvalid runs 4 cycles, lagging by 1, data in order. r0_rvalid stays 0.
- MAX_BURST=16, both valid continuously → grant pattern 16×r0, 16×r1, 16×r0. Zero idle cycles on bram_en.
- r0 writes 0x0123 to addr 7 in cycle T, r1 reads addr 7 at T+1 → r1_rvalid at T+2 with rdata 0x0123.
- rst pulsed the cycle after an accepted read → r0_rvalid and r1_rvalid stay 0, bram_en=0 during reset, FSM returns to IDLE.
- FM_BRAM_ARB_STATS_EN defined, 10 r0 accepts, 6 r1 accepts, 5 contended cycles → stat_grant0=10, stat_grant1=6, stat_conflict=5.
